// File: rtl/burst_stim_gen.sv
// Burst stimulus generator: NCH counting lanes emitted in bursts of BURST_LEN accepted
// beats separated by IDLE_LEN idle cycles, for a fixed number of bursts or forever.
module burst_stim_gen #(
    parameter int DW        = 4,
    parameter int NCH       = 2,
    parameter int BURST_LEN = 10,
    parameter int IDLE_LEN  = 10,
    parameter int REP_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [REP_W-1:0]    cfg_rep,
    input  logic [DW-1:0]       cfg_step,
    output logic                o_valid,
    output logic [NCH*DW-1:0]   o_data,
    input  logic                i_ready,
    output logic                busy,
    output logic                done
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (IDLE_LEN > 1) ? $clog2(IDLE_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((IDLE_LEN > 0) ? IDLE_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic                inf_q, inf_d;
    logic [DW-1:0]       step_q, step_d;
    logic [NCH*DW-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                more;

    // Lane k starts at k (mod 2^DW).
    function automatic logic [NCH*DW-1:0] lanes_init();
        logic [NCH*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            r[k*DW +: DW] = DW'(k);
        end
        return r;
    endfunction

    // Per-lane wrapping add; no saturation.
    function automatic logic [NCH*DW-1:0] lanes_step(input logic [NCH*DW-1:0] d,
                                                     input logic [DW-1:0]     s);
        logic [NCH*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            r[k*DW +: DW] = d[k*DW +: DW] + s;
        end
        return r;
    endfunction

    assign accept = valid_q & i_ready;
    // Bursts still to run after the one currently completing.
    assign more   = inf_q | (rep_q > REP_W'(1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        rep_d   = rep_q;
        inf_d   = inf_q;
        step_d  = step_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    rep_d   = cfg_rep;
                    inf_d   = (cfg_rep == '0);
                    step_d  = cfg_step;
                    data_d  = lanes_init();
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (accept) begin
                    data_d = lanes_step(data_q, step_q);
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        if (!inf_q) begin
                            rep_d = rep_q - REP_W'(1);
                        end
                        if (IDLE_LEN > 0) begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else if (!more) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (inf_q || (rep_q != '0)) begin
                        beat_d  = '0;
                        state_d = S_BURST;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort keeps any beat accepted this cycle but suppresses completion.
        if (stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    assign valid_d = (state_d == S_BURST);
    assign busy_d  = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            inf_q   <= 1'b0;
            step_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            inf_q   <= inf_d;
            step_q  <= step_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
